// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the EX/MEM stages.
// Memop one-hot bit map, FSM state encodings and SRAM-like size codes.
// No logic; constants only.
package dmem_ctrl_pkg;

  localparam int MEMOP_W = 12;

  // One-hot memop bit positions
  localparam int MOP_LB  = 0;
  localparam int MOP_LBU = 1;
  localparam int MOP_LH  = 2;
  localparam int MOP_LHU = 3;
  localparam int MOP_LW  = 4;
  localparam int MOP_SB  = 5;
  localparam int MOP_SH  = 6;
  localparam int MOP_SW  = 7;
  localparam int MOP_LWL = 8;
  localparam int MOP_LWR = 9;
  localparam int MOP_SWL = 10;
  localparam int MOP_SWR = 11;

  // Controller FSM states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_CANCEL = 3'd4;

  // data_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dmem_store_align.sv
// Decodes a memop into port size, byte strobes and lane-aligned store data.
// Purely combinational, zero latency.
// No handshake; the caller registers the outputs.
module dmem_store_align
  import dmem_ctrl_pkg::*;
(
  input  logic [MEMOP_W-1:0] memop,
  input  logic [1:0]         a,
  input  logic [31:0]        rt,
  output logic [1:0]         size,
  output logic [3:0]         wstrb,
  output logic [31:0]        wdata,
  output logic               word_align
);

  logic is_byte;
  logic is_half;
  logic is_word;

  assign is_byte    = memop[MOP_LB] | memop[MOP_LBU] | memop[MOP_SB];
  assign is_half    = memop[MOP_LH] | memop[MOP_LHU] | memop[MOP_SH];
  // Unaligned-word ops always talk to the containing aligned word
  assign word_align = memop[MOP_LWL] | memop[MOP_LWR] | memop[MOP_SWL] | memop[MOP_SWR];
  assign is_word    = memop[MOP_LW] | memop[MOP_SW] | word_align;

  // Size, strobes and data lane placement for each store flavour; loads write no bytes
  always_comb begin
    size  = SIZE_BYTE;
    wstrb = 4'b0000;
    wdata = rt;
    if (is_byte)      size = SIZE_BYTE;
    else if (is_half) size = SIZE_HALF;
    else if (is_word) size = SIZE_WORD;

    if (memop[MOP_SB]) begin
      wstrb = 4'b0001 << a;
      wdata = {4{rt[7:0]}};
    end else if (memop[MOP_SH]) begin
      wstrb = a[1] ? 4'b1100 : 4'b0011;
      wdata = {2{rt[15:0]}};
    end else if (memop[MOP_SW]) begin
      wstrb = 4'b1111;
      wdata = rt;
    end else if (memop[MOP_SWL]) begin
      // Most-significant bytes of rt land in the low lanes up to address a
      wstrb = 4'b1111 >> (2'd3 - a);
      wdata = rt >> {(2'd3 - a), 3'b000};
    end else if (memop[MOP_SWR]) begin
      // Least-significant bytes of rt land from address a upward
      wstrb = 4'b1111 << a;
      wdata = rt << {a, 3'b000};
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Sequences EX-stage loads/stores onto the SRAM-like data port, one at a time.
// Minimum 4 cycles per access (accept, req, wait, done); no overlap.
// Stalls the pipeline via stallreq_o until the response; absorbs flushed responses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MMOP_W = MEMOP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [MMOP_W-1:0] ex_memop_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [31:0]       ex_rt_i,
  input  logic              flush_i,
  input  logic              pipe_stall_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       mem_memdata_o,
  output logic              stallreq_o
);

  logic [2:0]  state;
  logic        access;
  logic        is_wr;
  logic [1:0]  al_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic        al_word_align;

  assign access = ex_valid_i & (|ex_memop_i);
  assign is_wr  = (|ex_memop_i[MOP_SW:MOP_SB]) | (|ex_memop_i[MOP_SWR:MOP_SWL]);

  dmem_store_align u_align (
    .memop      (ex_memop_i),
    .a          (ex_addr_i[1:0]),
    .rt         (ex_rt_i),
    .size       (al_size),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .word_align (al_word_align)
  );

  assign data_req = (state == S_REQ);

  // Access FSM, request field capture and read-word capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      data_wr       <= 1'b0;
      data_size     <= 2'd0;
      data_addr     <= 32'd0;
      data_wstrb    <= 4'd0;
      data_wdata    <= 32'd0;
      mem_memdata_o <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && !flush_i) begin
            state      <= S_REQ;
            data_wr    <= is_wr;
            data_size  <= al_size;
            data_addr  <= al_word_align ? {ex_addr_i[31:2], 2'b00} : ex_addr_i;
            data_wstrb <= al_wstrb;
            data_wdata <= al_wdata;
          end
        end
        S_REQ: begin
          // Once accepted, a response is owed even if the instruction is flushed
          if (data_addr_ok)  state <= flush_i ? S_CANCEL : S_WAIT;
          else if (flush_i)  state <= S_IDLE;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (flush_i) begin
              state <= S_IDLE;
            end else begin
              state         <= S_DONE;
              mem_memdata_o <= data_rdata;
            end
          end else if (flush_i) begin
            state <= S_CANCEL;
          end
        end
        S_DONE: begin
          // Same instruction still sits in EX until the pipeline advances
          if (!pipe_stall_i || flush_i) state <= S_IDLE;
        end
        S_CANCEL: begin
          if (data_data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall request: raised from acceptance until the response has been captured
  always_comb begin
    stallreq_o = 1'b0;
    case (state)
      S_IDLE:                  stallreq_o = access & ~flush_i;
      S_REQ, S_WAIT, S_CANCEL: stallreq_o = 1'b1;
      default:                 stallreq_o = 1'b0;
    endcase
    if (rst) stallreq_o = 1'b0;
  end

  // A response with nothing outstanding means the interconnect broke protocol
  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (rst)
    !(data_data_ok && (state == S_IDLE || state == S_REQ || state == S_DONE)));

endmodule
